sample_collector: RTL and testbench
===================================

// Module: sample_collector
// PURPOSE
//  Reader side of the pin-controller sample bus. Round-robin polls NUM_CHANNELS pin controllers via
//  output_sample/channel_select, validates the returned sample_data word, detects new samples by
//  sample counter change, and queues {timestamp, channel, bit} records in a FIFO for the host path.
// PARAMETERS
//  NUM_CHANNELS  8   channels polled, 0..NUM_CHANNELS-1 (1..128)
//  FIFO_AW       6   FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high
//  enable         in   1   run polling; low -> finish current channel, then IDLE
//  clear          in   1   one-cycle pulse: flush FIFO, zero status counters, clear overflow
//  current_time   in   32  global time base
//  output_sample  out  1   sample request strobe to pin controllers (registered)
//  channel_select out  8   channel addressed by the strobe (registered)
//  sample_data    in   32  shared response bus {cnt[15:0], 12'hABC, 3'b111, bit}; undriven = invalid
//  fifo_rd        in   1   pop head entry; ignored when fifo_empty
//  fifo_dout      out  32  head entry {time[23:0], chan[6:0], bit}; show-ahead, 0 when empty
//  fifo_empty     out  1   FIFO empty
//  fifo_full      out  1   FIFO full
//  fifo_count     out  FIFO_AW+1  entries held
//  overflow       out  1   sticky: a new sample was dropped on full FIFO
//  drop_count     out  16  samples dropped on full FIFO, saturates at 16'hFFFF
//  missed_count   out  16  samples skipped between polls, saturating
// BEHAVIOUR
//  Reset: state IDLE, output_sample 0, channel_select 0, chan ptr 0, FIFO empty, fifo_dout 0,
//   overflow 0, drop_count 0, missed_count 0, last_cnt[0..N-1] all 0.
//  FSM IDLE -> SELECT -> WAIT -> CAPTURE -> (SELECT | IDLE); 3 cycles per channel.
//   IDLE: output_sample 0; enable=1 -> SELECT with chan ptr as left.
//   SELECT: output_sample=1, channel_select=ptr for exactly this cycle; controller registers response.
//   WAIT: output_sample 0; at end of cycle latch sample_data into cap_reg.
//   CAPTURE: valid = (cap_reg[15:1] == 15'h55E7) and no X/Z bits. If valid and cap_cnt != last_cnt[ptr]:
//    new sample. delta = cap_cnt - last_cnt[ptr] (16-bit modular); delta>1 -> missed_count += delta-1
//    (saturating). last_cnt[ptr] <= cap_cnt. Push {current_time[23:0], ptr[6:0], cap_reg[0]} unless full.
//    Invalid word: no push, last_cnt unchanged. ptr <= (ptr==N-1) ? 0 : ptr+1.
//    Next: enable=1 -> SELECT, else IDLE.
//  FIFO full at push: entry dropped, overflow<=1, drop_count+1 (saturating); last_cnt still updated.
//  Push and fifo_rd same cycle: both take effect (allowed when full; count unchanged).
//  fifo_rd when empty: ignored, no pointer change. Push into empty: fifo_dout valid next cycle.
//  clear: FIFO pointers, counters, overflow zeroed same edge; FSM, ptr and last_cnt untouched;
//   a push in the clear cycle is discarded.
//  reset mid-scan: everything returns to reset values; no partial entry written.
// TESTING
//  1. N=4, ch2 cnt 0->1 bit=1 at t=100: one entry {24'd?,7'd2,1}, time = current_time at CAPTURE; others no push.
//  2. Invalid bus (32'hZ / 32'h0) on all channels for 3 scans -> fifo_empty stays 1, counters 0.
//  3. ch0 cnt jumps 5->9 between polls -> one entry, missed_count=3; cnt 16'hFFFF->16'h0001 -> missed +1.
//  4. FIFO_AW=2: 5 new samples, no reads -> fifo_count=4, overflow=1, drop_count=1; push+pop when full -> count 4.
//  5. enable dropped during WAIT of ch1 -> CAPTURE ch1 completes, IDLE; re-enable resumes at ch2.
//  6. clear with 3 entries, overflow=1 -> next cycle empty, counters 0; reset mid-CAPTURE -> no entry.

Source files
------------

// File: rtl/sample_collector.sv
// Reader side of the pin-controller sample bus: round-robin polls the channels, keeps
// only words that carry the fixed marker, and queues {time, channel, bit} for the host.
module sample_collector #(
  parameter int NUM_CHANNELS = 8,
  parameter int FIFO_AW      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [31:0]        current_time,
  output logic               output_sample,
  output logic [7:0]         channel_select,
  input  logic [31:0]        sample_data,
  input  logic               fifo_rd,
  output logic [31:0]        fifo_dout,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic [15:0]        drop_count,
  output logic [15:0]        missed_count
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  // state     | meaning
  // S_IDLE    | not polling; leaves on enable
  // S_SELECT  | strobe high, channel_select = r_ptr
  // S_WAIT    | controller drives its response; latched into r_cap at end of cycle
  // S_CAPTURE | validate r_cap, detect new sample, push/drop, advance r_ptr
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SELECT  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_ptr;
  logic [31:0]         r_cap;
  logic [15:0]         r_last_cnt [2**CW];
  logic                r_output_sample;
  logic [7:0]          r_channel_select;

  logic [31:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  logic                r_overflow;
  logic [15:0]         r_drop;
  logic [15:0]         r_missed;

  logic [CW-1:0]       w_ptr_next;
  logic [15:0]         w_cap_cnt;
  logic [15:0]         w_last;
  logic [15:0]         w_delta;
  logic                w_valid;
  logic                w_new;
  logic                w_push;
  logic                w_full;
  logic                w_do_rd;
  logic                w_do_wr;
  logic                w_drop;
  logic [31:0]         w_entry;
  logic [16:0]         w_missed_sum;
  logic [15:0]         w_missed_next;
  logic                w_unused;

  assign w_ptr_next = (r_ptr == CW'(NUM_CHANNELS - 1)) ? '0 : r_ptr + CW'(1);
  assign w_cap_cnt  = r_cap[31:16];
  assign w_last     = r_last_cnt[r_ptr];
  assign w_delta    = w_cap_cnt - w_last;
  // A floating bus reads as X/Z in simulation; treat any unknown bit as no response.
  assign w_valid    = (r_cap[15:1] == 15'h55E7) && !$isunknown(r_cap);
  assign w_new      = (r_state == S_CAPTURE) && w_valid && (w_cap_cnt != w_last);
  assign w_push     = w_new && !clear && !reset;

  assign w_full     = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_do_rd    = fifo_rd && (r_count != '0);
  assign w_do_wr    = w_push && (!w_full || w_do_rd);
  assign w_drop     = w_push && w_full && !w_do_rd;
  assign w_entry    = {current_time[23:0], 7'(r_ptr), r_cap[0]};
  assign w_unused   = ^current_time[31:24];

  assign w_missed_sum  = {1'b0, r_missed} + {1'b0, w_delta} - 17'd1;
  assign w_missed_next = w_missed_sum[16] ? 16'hFFFF : w_missed_sum[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_ptr            <= '0;
      r_cap            <= '0;
      r_output_sample  <= 1'b0;
      r_channel_select <= '0;
      for (int i = 0; i < 2**CW; i++) r_last_cnt[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_output_sample <= 1'b0;
          if (enable) begin
            r_state          <= S_SELECT;
            r_output_sample  <= 1'b1;
            r_channel_select <= 8'(r_ptr);
          end
        end
        S_SELECT: begin
          r_output_sample <= 1'b0;
          r_state         <= S_WAIT;
        end
        S_WAIT: begin
          r_cap   <= sample_data;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (w_new) r_last_cnt[r_ptr] <= w_cap_cnt;
          r_ptr <= w_ptr_next;
          if (enable) begin
            r_state          <= S_SELECT;
            r_output_sample  <= 1'b1;
            r_channel_select <= 8'(w_ptr_next);
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state         <= S_IDLE;
          r_output_sample <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      unique case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear wins over a same-cycle increment, so a sample captured on the clear edge leaves no trace.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_overflow <= 1'b0;
      r_drop     <= '0;
      r_missed   <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
      if (w_new && (w_delta > 16'd1)) r_missed <= w_missed_next;
    end
  end

  assign output_sample  = r_output_sample;
  assign channel_select = r_channel_select;
  assign fifo_dout      = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
  assign fifo_empty     = (r_count == '0);
  assign fifo_full      = w_full;
  assign fifo_count     = r_count;
  assign overflow       = r_overflow;
  assign drop_count     = r_drop;
  assign missed_count   = r_missed;

endmodule

// File: tb/tb_sample_collector.sv
// Bench for sample_collector: pin-controller responder plus a queue-based reference model.
module tb_sample_collector;
  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, clear = 1'b0, fifo_rd = 1'b0;
  logic [31:0] current_time = '0, sample_data = '0;
  logic        output_sample, fifo_empty, fifo_full, overflow;
  logic [7:0]  channel_select;
  logic [31:0] fifo_dout;
  logic [AW:0] fifo_count;
  logic [15:0] drop_count, missed_count;

  sample_collector #(.NUM_CHANNELS(N), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .current_time(current_time), .output_sample(output_sample),
    .channel_select(channel_select), .sample_data(sample_data),
    .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow),
    .drop_count(drop_count), .missed_count(missed_count));

  always #5 clk = ~clk;
  always @(posedge clk) current_time <= current_time + 32'd1;

  // Pin controller state seen by the responder
  logic [15:0] ch_cnt [N];
  logic        ch_bit [N];
  logic        ch_ok  [N];

  // Reference model
  logic [31:0] mq[$];
  logic [15:0] m_last [N];
  int          m_missed, m_drop;
  logic        m_ovf;
  int          n_checks = 0, n_fail = 0;

  bit          pend_valid;
  int          pend_cd, pend_ch, exp_ch, n_strobes;
  logic [31:0] pend_word, mw;
  logic [15:0] mc, md;
  bit          prev_os;

  function automatic logic [31:0] make_word(int ch);
    if (ch_ok[ch]) return {ch_cnt[ch], 12'hABC, 3'b111, ch_bit[ch]};
    case ($urandom_range(2, 0))
      0:       return 32'hZZZZ_ZZZZ;
      1:       return 32'h0;
      default: return {ch_cnt[ch], 12'hABD, 3'b111, ch_bit[ch]};
    endcase
  endfunction

  function automatic logic [31:0] model_head();
    return (mq.size() > 0) ? mq[0] : 32'h0;
  endfunction

  // Responder + model: every strobe is answered next cycle and judged two edges later
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      for (int i = 0; i < N; i++) m_last[i] = '0;
      m_missed = 0; m_drop = 0; m_ovf = 1'b0;
      pend_valid = 0; exp_ch = 0; prev_os = 0;
    end else begin
      if (clear) begin
        mq.delete(); m_missed = 0; m_drop = 0; m_ovf = 1'b0;
      end else if (fifo_rd && mq.size() > 0) begin
        void'(mq.pop_front());
      end
      if (pend_valid) begin
        pend_cd--;
        if (pend_cd == 0) begin
          pend_valid = 0;
          mw = pend_word;
          mc = mw[31:16];
          if (mw[15:1] == 15'h55E7 && !$isunknown(mw) && mc != m_last[pend_ch]) begin
            md = mc - m_last[pend_ch];
            m_last[pend_ch] = mc;
            if (!clear) begin
              if (md > 16'd1) m_missed = (m_missed + int'(md) - 1 > 65535) ? 65535 : m_missed + int'(md) - 1;
              if (mq.size() < DEPTH) mq.push_back({current_time[23:0], 7'(pend_ch), mw[0]});
              else begin m_ovf = 1'b1; if (m_drop < 65535) m_drop++; end
            end
          end
        end
      end
      if (output_sample) begin
        n_checks++;
        if (prev_os || channel_select !== 8'(exp_ch)) begin
          n_fail++;
          $display("FAIL strobe_order: channel_select=%0d back_to_back=%0d, required ch %0d single-cycle",
                   channel_select, prev_os, exp_ch);
        end
        n_strobes++;
        mw = make_word(exp_ch);
        sample_data <= mw;
        pend_word  = mw;
        pend_ch    = exp_ch;
        pend_valid = 1;
        pend_cd    = 2;
        exp_ch     = (exp_ch + 1) % N;
      end
      prev_os = output_sample;
    end
  end

  task automatic run_scans(int n);
    enable = 1'b1;
    repeat (3 * N * n) @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain();
    fifo_rd = 1'b1;
    repeat (DEPTH + 1) @(negedge clk);
    fifo_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (output_sample !== 1'b0) begin n_fail++; $display("FAIL rst_os: got %0b want 0", output_sample); end
    n_checks++; if (channel_select !== 8'd0) begin n_fail++; $display("FAIL rst_cs: got %0d want 0", channel_select); end
    n_checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL rst_flags: empty=%0b full=%0b want 1/0", fifo_empty, fifo_full); end
    n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_checks++; if (fifo_dout !== 32'h0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", fifo_dout); end
    n_checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || missed_count !== 16'd0) begin n_fail++; $display("FAIL rst_status: ovf=%0b drop=%0d missed=%0d want 0", overflow, drop_count, missed_count); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (output_sample !== 1'b0) begin n_fail++; $display("FAIL idle_os: got %0b want 0", output_sample); end
  endtask

  task automatic test_single_new();
    for (int i = 0; i < N; i++) begin ch_ok[i] = 1'b1; ch_cnt[i] = '0; ch_bit[i] = 1'b0; end
    ch_cnt[2] = 16'd1; ch_bit[2] = 1'b1;
    run_scans(1);
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    n_checks++; if (fifo_dout[7:0] !== {7'd2, 1'b1}) begin n_fail++; $display("FAIL single_chan_bit: got %h want %h", fifo_dout[7:0], {7'd2, 1'b1}); end
    n_checks++; if (fifo_dout !== model_head()) begin n_fail++; $display("FAIL single_entry: got %h want %h", fifo_dout, model_head()); end
    drain();
    n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL single_drain: empty=%0b want 1", fifo_empty); end
  endtask

  task automatic test_invalid_bus();
    for (int i = 0; i < N; i++) begin ch_ok[i] = 1'b0; ch_cnt[i] = 16'($urandom_range(65535, 100)); end
    run_scans(3);
    n_checks++; if (fifo_empty !== 1'b1 || fifo_count !== '0) begin n_fail++; $display("FAIL invalid_fifo: empty=%0b count=%0d want 1/0", fifo_empty, fifo_count); end
    n_checks++; if (missed_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL invalid_counters: missed=%0d drop=%0d ovf=%0b want 0", missed_count, drop_count, overflow); end
  endtask

  task automatic test_missed();
    for (int i = 0; i < N; i++) begin ch_ok[i] = 1'b1; ch_cnt[i] = m_last[i]; end
    ch_cnt[0] = 16'd5; run_scans(1);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    ch_cnt[0] = 16'd9; run_scans(1);
    n_checks++; if (missed_count !== 16'd3) begin n_fail++; $display("FAIL missed_5_9: got %0d want 3", missed_count); end
    n_checks++; if (fifo_count !== 3'd1 || fifo_dout !== model_head()) begin n_fail++; $display("FAIL missed_entry: count=%0d dout=%h want 1/%h", fifo_count, fifo_dout, model_head()); end
    drain();
    ch_cnt[0] = 16'hFFFF; run_scans(1);
    n_checks++; if (missed_count !== 16'(m_missed)) begin n_fail++; $display("FAIL missed_big: got %0d want %0d", missed_count, m_missed); end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    ch_cnt[0] = 16'h0001; run_scans(1);
    n_checks++; if (missed_count !== 16'd1) begin n_fail++; $display("FAIL missed_wrap: got %0d want 1", missed_count); end
    drain();
  endtask

  task automatic test_overflow();
    bit found = 0;
    for (int i = 0; i < N; i++) ch_cnt[i] = ch_cnt[i] + 16'd1;
    run_scans(1);
    ch_cnt[0] = ch_cnt[0] + 16'd1;
    run_scans(1);
    n_checks++; if (fifo_count !== 3'd4 || fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_count: count=%0d full=%0b want 4/1", fifo_count, fifo_full); end
    n_checks++; if (overflow !== 1'b1 || drop_count !== 16'd1) begin n_fail++; $display("FAIL ovf_drop: ovf=%0b drop=%0d want 1/1", overflow, drop_count); end
    ch_cnt[1] = ch_cnt[1] + 16'd1;
    enable = 1'b1;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (pend_valid && pend_ch == 1 && pend_cd == 1) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL ovf_wait: no capture of ch1 within 60 cycles"); end
    fifo_rd = 1'b1; @(negedge clk); fifo_rd = 1'b0;
    n_checks++; if (fifo_count !== 3'd4 || drop_count !== 16'd1) begin n_fail++; $display("FAIL push_pop_full: count=%0d drop=%0d want 4/1", fifo_count, drop_count); end
    n_checks++; if (fifo_dout !== model_head()) begin n_fail++; $display("FAIL push_pop_head: got %h want %h", fifo_dout, model_head()); end
    enable = 1'b0;
    repeat (4) @(negedge clk);
    drain();
  endtask

  task automatic test_enable_drop();
    bit found = 0;
    int snap;
    ch_cnt[1] = ch_cnt[1] + 16'd1; ch_bit[1] = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (pend_valid && pend_ch == 1 && pend_cd == 2) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL drop_wait: no WAIT of ch1 within 60 cycles"); end
    enable = 1'b0;
    snap = n_strobes;
    repeat (6) @(negedge clk);
    n_checks++; if (n_strobes !== snap || output_sample !== 1'b0) begin n_fail++; $display("FAIL drop_idle: strobes=%0d os=%0b want %0d/0", n_strobes, output_sample, snap); end
    n_checks++; if (fifo_count !== 3'd1 || fifo_dout[7:0] !== {7'd1, 1'b1}) begin n_fail++; $display("FAIL drop_capture: count=%0d low=%h want 1/%h", fifo_count, fifo_dout[7:0], {7'd1, 1'b1}); end
    enable = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (output_sample === 1'b1) found = 1;
    end
    n_checks++; if (!found || channel_select !== 8'd2) begin n_fail++; $display("FAIL resume_ch: seen=%0b cs=%0d want 1/2", found, channel_select); end
    enable = 1'b0;
    repeat (4) @(negedge clk);
    drain();
  endtask

  task automatic test_clear_and_reset();
    bit found = 0;
    for (int i = 0; i < N; i++) ch_cnt[i] = ch_cnt[i] + 16'd1;
    run_scans(1);
    for (int i = 0; i < N; i++) ch_cnt[i] = ch_cnt[i] + 16'd1;
    run_scans(1);
    fifo_rd = 1'b1; @(negedge clk); fifo_rd = 1'b0;
    n_checks++; if (fifo_count !== 3'd3 || overflow !== 1'b1) begin n_fail++; $display("FAIL clear_pre: count=%0d ovf=%0b want 3/1", fifo_count, overflow); end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    n_checks++; if (fifo_empty !== 1'b1 || fifo_count !== '0 || fifo_dout !== 32'h0) begin n_fail++; $display("FAIL clear_fifo: empty=%0b count=%0d dout=%h want 1/0/0", fifo_empty, fifo_count, fifo_dout); end
    n_checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || missed_count !== 16'd0) begin n_fail++; $display("FAIL clear_status: ovf=%0b drop=%0d missed=%0d want 0", overflow, drop_count, missed_count); end
    ch_cnt[3] = ch_cnt[3] + 16'd1;
    enable = 1'b1;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (pend_valid && pend_ch == 3 && pend_cd == 1) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rst_cap_wait: no capture of ch3 within 60 cycles"); end
    reset = 1'b1; @(negedge clk);
    reset = 1'b0; enable = 1'b0; @(negedge clk);
    n_checks++; if (fifo_empty !== 1'b1 || fifo_count !== '0 || output_sample !== 1'b0) begin n_fail++; $display("FAIL rst_mid_capture: empty=%0b count=%0d os=%0b want 1/0/0", fifo_empty, fifo_count, output_sample); end
  endtask

  task automatic test_random();
    int ch;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      n_checks++; if (fifo_count !== (AW+1)'(mq.size())) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, fifo_count, mq.size()); end
      n_checks++; if (fifo_dout !== model_head()) begin n_fail++; $display("FAIL rnd_dout @%0d: got %h want %h", cyc, fifo_dout, model_head()); end
      n_checks++; if (fifo_empty !== (mq.size() == 0) || fifo_full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_flags @%0d: empty=%0b full=%0b size %0d", cyc, fifo_empty, fifo_full, mq.size()); end
      n_checks++; if (overflow !== m_ovf || drop_count !== 16'(m_drop)) begin n_fail++; $display("FAIL rnd_drop @%0d: ovf=%0b drop=%0d want %0b/%0d", cyc, overflow, drop_count, m_ovf, m_drop); end
      n_checks++; if (missed_count !== 16'(m_missed)) begin n_fail++; $display("FAIL rnd_missed @%0d: got %0d want %0d", cyc, missed_count, m_missed); end
      enable  = ($urandom_range(7, 0) != 0);
      fifo_rd = ($urandom_range(2, 0) == 0);
      clear   = ($urandom_range(199, 0) == 0);
      if ($urandom_range(9, 0) == 0) begin
        ch = $urandom_range(N - 1, 0);
        ch_ok[ch]  = ($urandom_range(9, 0) != 0);
        ch_bit[ch] = 1'($urandom_range(1, 0));
        if ($urandom_range(1, 0) == 0) ch_cnt[ch] = ch_cnt[ch] + 16'($urandom_range(3, 1));
        else ch_cnt[ch] = 16'($urandom);
      end
    end
    enable = 1'b0; fifo_rd = 1'b0; clear = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin ch_cnt[i] = '0; ch_bit[i] = 1'b0; ch_ok[i] = 1'b0; end
    n_strobes = 0;
    test_reset();
    test_single_new();
    test_invalid_bus();
    test_missed();
    test_overflow();
    test_enable_drop();
    test_clear_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
